// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per SHIFT cycle.
// Define BCD_LZ_BLANK_EN to produce the leading-zero blank mask; otherwise blank is tied to 0.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  ready,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    sr_q, sr_d;
    logic [4*DIGITS-1:0] dig_q, dig_d;
    logic [4*DIGITS-1:0] adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                valid_q, valid_d;

    // Add-3 correction on every digit that would overflow past 9 after doubling.
    always_comb begin
        adj = dig_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (dig_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = bin_in;
                    dig_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                dig_d = {adj[4*DIGITS-2:0], sr_q[WIDTH-1]};
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = dig_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign valid   = valid_q;
    assign bcd_out = bcd_q;

`ifdef BCD_LZ_BLANK_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] lz;
    logic              allZero;

    // Scan from the most significant digit down; the units digit is never blanked.
    always_comb begin
        lz      = '0;
        allZero = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            allZero = allZero & (dig_q[4*k +: 4] == 4'd0);
            lz[k]   = allZero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= '0;
        end else if (state_q == DONE) begin
            blank_q <= lz;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: cycle-level reference model for the default
// configuration plus directed checks on a WIDTH=8/DIGITS=3 instance.
module tb_bin_to_bcd_seq;

    localparam int W  = 32;
    localparam int D  = 10;
    localparam int W2 = 8;
    localparam int D2 = 3;

`ifdef BCD_LZ_BLANK_EN
    localparam logic [D-1:0]  BLANK_ZERO  = 10'b1111111110;
    localparam logic [D-1:0]  BLANK_907   = 10'b1111111000;
    localparam logic [D-1:0]  BLANK_8DIG  = 10'b1100000000;
    localparam logic [D2-1:0] BLANK2_ZERO = 3'b110;
`else
    localparam logic [D-1:0]  BLANK_ZERO  = '0;
    localparam logic [D-1:0]  BLANK_907   = '0;
    localparam logic [D-1:0]  BLANK_8DIG  = '0;
    localparam logic [D2-1:0] BLANK2_ZERO = '0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [W-1:0]      binIn = '0;
    logic              ready, valid;
    logic [4*D-1:0]    bcdOut;
    logic [D-1:0]      blank;

    logic              rst2 = 1'b1;
    logic              start2 = 1'b0;
    logic [W2-1:0]     binIn2 = '0;
    logic              ready2, valid2;
    logic [4*D2-1:0]   bcdOut2;
    logic [D2-1:0]     blank2;

    int checks = 0;
    int failures = 0;

    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(binIn),
        .ready(ready), .valid(valid), .bcd_out(bcdOut), .blank(blank)
    );

    bin_to_bcd_seq #(.WIDTH(W2), .DIGITS(D2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .bin_in(binIn2),
        .ready(ready2), .valid(valid2), .bcd_out(bcdOut2), .blank(blank2)
    );

    function automatic int numDigits(input longint unsigned v);
        int n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    function automatic logic [4*D-1:0] toBcd(input longint unsigned v);
        logic [4*D-1:0] r = '0;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [4*D2-1:0] toBcd2(input longint unsigned v);
        logic [4*D2-1:0] r = '0;
        for (int k = 0; k < D2; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [D-1:0] blankOf(input longint unsigned v);
        logic [D-1:0] b = '0;
`ifdef BCD_LZ_BLANK_EN
        for (int k = 1; k < D; k++) b[k] = (k >= numDigits(v));
`endif
        return b;
    endfunction

    function automatic logic [D2-1:0] blankOf2(input longint unsigned v);
        logic [D2-1:0] b = '0;
`ifdef BCD_LZ_BLANK_EN
        for (int k = 1; k < D2; k++) b[k] = (k >= numDigits(v));
`endif
        return b;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a conversion finishes WIDTH+1 edges after the accepting edge.
    logic           modelOn = 1'b0;
    logic           busy = 1'b0;
    int             remain = 0;
    logic [W-1:0]   pending = '0;
    logic           expReady = 1'b1;
    logic           expValid = 1'b0;
    logic [4*D-1:0] expBcd = '0;
    logic [D-1:0]   expBlank = '0;

    always @(posedge clk) begin
        if (rst) begin
            modelOn  <= 1'b1;
            busy     <= 1'b0;
            remain   <= 0;
            expReady <= 1'b1;
            expValid <= 1'b0;
            expBcd   <= '0;
            expBlank <= '0;
        end else begin
            expValid <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy     <= 1'b1;
                    pending  <= binIn;
                    remain   <= W + 1;
                    expReady <= 1'b0;
                end
            end else if (remain == 1) begin
                busy     <= 1'b0;
                expReady <= 1'b1;
                expValid <= 1'b1;
                expBcd   <= toBcd(longint'(pending));
                expBlank <= blankOf(longint'(pending));
            end else begin
                remain <= remain - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            checkVal("ready",   64'(ready),    64'(expReady));
            checkVal("valid",   64'(valid),    64'(expValid));
            checkVal("bcd_out", 64'(bcdOut),   64'(expBcd));
            checkVal("blank",   64'(blank),    64'(expBlank));
        end
    end

    task automatic applyStimulus(input logic [W-1:0] v);
        @(negedge clk);
        start = 1'b1;
        binIn = v;
        @(negedge clk);
        start = 1'b0;
        binIn = $urandom;
    endtask

    task automatic waitValid(output int n);
        n = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [4*D-1:0] eBcd, input logic [D-1:0] eBlank);
        int n;
        waitValid(n);
        if (n < 0) begin
            checkVal({name, "_timeout"}, 64'(0), 64'(1));
        end else begin
            checkVal({name, "_bcd"},   64'(bcdOut), 64'(eBcd));
            checkVal({name, "_blank"}, 64'(blank),  64'(eBlank));
        end
    endtask

    task automatic convert2(input logic [W2-1:0] v, output int lat);
        @(negedge clk);
        start2 = 1'b1;
        binIn2 = v;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        binIn2 = ~v;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (valid2 === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int lat;
        logic [W2-1:0] v2;

        repeat (3) @(negedge clk);
        checkVal("reset_ready", 64'(ready),  64'(1));
        checkVal("reset_valid", 64'(valid),  64'(0));
        checkVal("reset_bcd",   64'(bcdOut), 64'(0));
        checkVal("reset_blank", 64'(blank),  64'(0));
        rst = 1'b0;

        applyStimulus(32'd0);
        waitValid(n);
        checkVal("zero_latency", 64'(n), 64'(32));
        checkVal("zero_bcd",   64'(bcdOut), 64'(0));
        checkVal("zero_blank", 64'(blank),  64'(BLANK_ZERO));

        applyStimulus(32'hFFFF_FFFF);
        checkOutput("max", 40'h42_9496_7295, '0);

        applyStimulus(32'd907);
        checkOutput("v907", 40'h907, BLANK_907);

        // Start held high throughout: only the first operand is used until ready returns.
        @(negedge clk);
        start = 1'b1;
        binIn = 32'd5;
        @(negedge clk);
        binIn = 32'd99;
        checkOutput("held_first", 40'h5, BLANK_ZERO);
        @(negedge clk);
        start = 1'b0;
        checkOutput("held_second", 40'h99, blankOf(99));

        applyStimulus(32'd12345678);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkVal("abort_ready", 64'(ready),  64'(1));
        checkVal("abort_valid", 64'(valid),  64'(0));
        checkVal("abort_bcd",   64'(bcdOut), 64'(0));
        applyStimulus(32'd12345678);
        checkOutput("after_abort", 40'h12345678, BLANK_8DIG);

        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 399) == 0);
            start = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: binIn = $urandom;
                1: binIn = W'($urandom_range(0, 99));
                2: binIn = 32'hFFFF_FFFF - W'($urandom_range(0, 9));
                default: binIn = $urandom >> $urandom_range(0, 31);
            endcase
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (80) @(negedge clk);

        @(negedge clk);
        checkVal("w8_reset_ready", 64'(ready2),  64'(1));
        checkVal("w8_reset_valid", 64'(valid2),  64'(0));
        checkVal("w8_reset_bcd",   64'(bcdOut2), 64'(0));
        rst2 = 1'b0;

        convert2(8'd255, lat);
        checkVal("w8_255_latency", 64'(lat),     64'(9));
        checkVal("w8_255_bcd",     64'(bcdOut2), 64'(12'h255));
        checkVal("w8_255_blank",   64'(blank2),  64'(0));

        convert2(8'd0, lat);
        checkVal("w8_0_latency", 64'(lat),     64'(9));
        checkVal("w8_0_bcd",     64'(bcdOut2), 64'(0));
        checkVal("w8_0_blank",   64'(blank2),  64'(BLANK2_ZERO));

        for (int i = 0; i < 8; i++) begin
            v2 = W2'($urandom_range(0, 255));
            convert2(v2, lat);
            checkVal("w8_rand_latency", 64'(lat),     64'(9));
            checkVal("w8_rand_bcd",     64'(bcdOut2), 64'(toBcd2(longint'(v2))));
            checkVal("w8_rand_blank",   64'(blank2),  64'(blankOf2(longint'(v2))));
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
